alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 32 +++
 rtl/muldiv_seq.sv | 119 +++++++++++
 rtl/alu_mc.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - ALUOp code constants (5-bit)
//   - FSM state enumeration for the iterative multiply/divide unit
//   - request struct handed from the ALU front end to the mul/div unit
package alu_pkg;

  localparam logic [4:0] OP_SLL   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
  localparam logic [4:0] OP_MULT  = 5'd11;
  localparam logic [4:0] OP_MULTU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_MFHI  = 5'd15;
  localparam logic [4:0] OP_MFLO  = 5'd16;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  typedef struct packed {
    logic is_div;  // 1: divide, 0: multiply
    logic sgn;     // signed operands
  } md_req_t;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply / restoring divide, one bit per cycle.
//   clk, rst      : clock, synchronous active-high reset
//   go            : accepted mul/div request (only honoured in IDLE)
//   req           : operation kind (div/mul, signed/unsigned)
//   a, b          : operands (a = dividend / multiplicand side, b = divisor)
//   busy          : state != IDLE
//   res_vld       : high in FIX; res_hi/res_lo carry the final HI/LO
//   res_hi, res_lo: sign-corrected result, valid while res_vld
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int BIT_SIZE = 32,
  parameter int SH_W     = $clog2(BIT_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  md_req_t             req,
  input  logic [BIT_SIZE-1:0] a,
  input  logic [BIT_SIZE-1:0] b,
  output logic                busy,
  output logic                res_vld,
  output logic [BIT_SIZE-1:0] res_hi,
  output logic [BIT_SIZE-1:0] res_lo
);

  state_t              state;
  logic [SH_W-1:0]     cnt;
  logic [BIT_SIZE-1:0] hi_r, lo_r, opnd;
  logic                is_div_r, neg_q, neg_r, dvz;

  // Work on magnitudes; the sign is re-applied in FIX.
  logic                a_neg, b_neg;
  logic [BIT_SIZE-1:0] a_mag, b_mag;
  assign a_neg = req.sgn & a[BIT_SIZE-1];
  assign b_neg = req.sgn & b[BIT_SIZE-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  logic last;
  assign last = (cnt == SH_W'(BIT_SIZE-1));

  // Shift-add step: conditionally add multiplicand to the upper half,
  // then shift the whole {hi,lo} pair right by one.
  logic [BIT_SIZE:0] mul_sum;
  assign mul_sum = {1'b0, hi_r} + ({(BIT_SIZE+1){lo_r[0]}} & {1'b0, opnd});

  // Restoring step: shift next dividend bit into the remainder, trial subtract.
  logic [BIT_SIZE:0] trial;
  assign trial = {hi_r, lo_r[BIT_SIZE-1]} - {1'b0, opnd};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      opnd     <= '0;
      is_div_r <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvz      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          state    <= req.is_div ? ST_DIV : ST_MUL;
          cnt      <= '0;
          hi_r     <= '0;
          lo_r     <= a_mag;
          opnd     <= b_mag;
          is_div_r <= req.is_div;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          dvz      <= (b == '0);
        end
        ST_MUL: begin
          {hi_r, lo_r} <= {mul_sum, lo_r[BIT_SIZE-1:1]};
          cnt          <= cnt + 1'b1;
          if (last) begin
            state <= ST_FIX;
            cnt   <= '0;
          end
        end
        ST_DIV: begin
          hi_r <= trial[BIT_SIZE] ? {hi_r[BIT_SIZE-2:0], lo_r[BIT_SIZE-1]}
                                  : trial[BIT_SIZE-1:0];
          lo_r <= {lo_r[BIT_SIZE-2:0], ~trial[BIT_SIZE]};
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= ST_FIX;
            cnt   <= '0;
          end
        end
        ST_FIX:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign res_vld = (state == ST_FIX);

  // With a zero divisor the remainder path naturally ends holding |a|, and
  // neg_r restores a's sign, so HI=a falls out; only LO needs forcing.
  // Most-negative / -1 also falls out: |q| = 2^(n-1), quotient positive.
  logic [2*BIT_SIZE-1:0] prod, prod_fix;
  assign prod     = {hi_r, lo_r};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*BIT_SIZE-1:BIT_SIZE];
    res_lo = prod_fix[BIT_SIZE-1:0];
    if (is_div_r) begin
      res_hi = neg_r ? -hi_r : hi_r;
      res_lo = dvz ? '1 : (neg_q ? -lo_r : lo_r);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle ops complete at the accepting edge;
// mult/div run in muldiv_seq (BIT_SIZE+2 cycles to done).
//   clk, rst        : clock, synchronous active-high reset
//   start, ALUOp    : request + opcode, accepted only when busy=0
//   src1, src2      : operands; shamt: shift amount (shifts act on src2)
//   ALU_result, Zero: registered result and its zero flag
//   busy, done      : mul/div in flight / one-cycle completion pulse
//   HI, LO          : mul/div result registers
module alu_mc
  import alu_pkg::*;
#(
  parameter int BIT_SIZE = 32,
  parameter int SH_W     = $clog2(BIT_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          ALUOp,
  input  logic [BIT_SIZE-1:0] src1,
  input  logic [BIT_SIZE-1:0] src2,
  input  logic [SH_W-1:0]     shamt,
  output logic [BIT_SIZE-1:0] ALU_result,
  output logic                Zero,
  output logic                busy,
  output logic                done,
  output logic [BIT_SIZE-1:0] HI,
  output logic [BIT_SIZE-1:0] LO
);

  logic    is_md, acc, go, res_vld;
  md_req_t req;
  logic [BIT_SIZE-1:0] res_hi, res_lo, sc_res;

  assign is_md      = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) ||
                      (ALUOp == OP_DIV)  || (ALUOp == OP_DIVU);
  assign req.is_div = (ALUOp == OP_DIV)  || (ALUOp == OP_DIVU);
  assign req.sgn    = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
  assign acc        = start & ~busy;
  assign go         = acc & is_md;

  muldiv_seq #(.BIT_SIZE(BIT_SIZE), .SH_W(SH_W)) u_md (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .req     (req),
    .a       (src1),
    .b       (src2),
    .busy    (busy),
    .res_vld (res_vld),
    .res_hi  (res_hi),
    .res_lo  (res_lo)
  );

  always_comb begin
    sc_res = '0;
    case (ALUOp)
      OP_SLL:  sc_res = src2 << shamt;
      OP_ADD:  sc_res = src1 + src2;
      OP_SUB:  sc_res = src1 - src2;
      OP_AND:  sc_res = src1 & src2;
      OP_OR:   sc_res = src1 | src2;
      OP_XOR:  sc_res = src1 ^ src2;
      OP_NOR:  sc_res = ~(src1 | src2);
      OP_SLT:  sc_res = {{(BIT_SIZE-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SRL:  sc_res = src2 >> shamt;
      OP_SRA:  sc_res = $signed(src2) >>> shamt;
      OP_SLTU: sc_res = {{(BIT_SIZE-1){1'b0}}, src1 < src2};
      OP_MFHI: sc_res = HI;
      OP_MFLO: sc_res = LO;
      default: sc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_result <= '0;
      HI         <= '0;
      LO         <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (res_vld) begin
        HI         <= res_hi;
        LO         <= res_lo;
        ALU_result <= res_lo;
        done       <= 1'b1;
      end else if (acc && !is_md) begin
        ALU_result <= sc_res;
        done       <= 1'b1;
      end
    end
  end

  assign Zero = (ALU_result == '0);

endmodule
